// File: rtl/lc4_perf_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lc4_perf_pkg
// Brief   : Shared encodings for the LC4 performance monitor (controller
//           states and stall-class codes) plus counter index constants.
// Revision: 1.0 - initial release
// ============================================================================
package lc4_perf_pkg;

  // Controller states as seen on o_state
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } perf_state_e;

  // Stall-class codes presented on i_stall_class
  typedef enum logic [1:0] {
    CLS_EXEC   = 2'd0,
    CLS_CACHE  = 2'd1,
    CLS_BRANCH = 2'd2,
    CLS_LOAD   = 2'd3
  } stall_class_e;

  // Counter bank layout: slot 0 is total cycles, class k lives in slot k+1
  localparam int c_idx_total = 0;
  localparam int c_idx_exec  = 1;

endpackage
`default_nettype wire

// File: rtl/lc4_perf_counter.sv
`default_nettype none
// ============================================================================
// Module  : lc4_perf_counter
// Brief   : CNT_W-bit event counter with selectable wrap/saturate behaviour
//           and a sticky overflow flag. Clear has priority over increment.
// Revision: 1.0 - initial release
// ============================================================================
module lc4_perf_counter #(
  parameter int CNT_W    = 32,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  // Next count: clear wins; an increment from all-ones flags overflow and
  // either wraps to zero or sticks at all-ones
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (inc_i) begin
      if (&cnt_q) begin
        ovf_d = 1'b1;
        cnt_d = (SATURATE != 0) ? cnt_q : '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Count and overflow registers, asynchronously cleared by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule
`default_nettype wire

// File: rtl/lc4_perf_monitor.sv
`default_nettype none
// ============================================================================
// Module  : lc4_perf_monitor
// Brief   : LC4 performance monitor. Counts total cycles and per-class stall
//           cycles while running, stops automatically at an exec-count target,
//           and exposes a snapshot bank through a combinational read mux.
// Revision: 1.0 - initial release
// ============================================================================
module lc4_perf_monitor
  import lc4_perf_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int NUM_CLASSES = 4,
  parameter int CLS_W       = 2,
  parameter int SATURATE    = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               gwe,
  input  logic [CLS_W-1:0]                   i_stall_class,
  input  logic                               i_start,
  input  logic                               i_stop,
  input  logic                               i_clear,
  input  logic [CNT_W-1:0]                   i_target,
  input  logic                               i_snap,
  input  logic [$clog2(NUM_CLASSES+1)-1:0]   i_rd_sel,
  output logic [CNT_W-1:0]                   o_rd_data,
  output logic [NUM_CLASSES:0]               o_ovf,
  output logic [1:0]                         o_state,
  output logic                               o_done
);

  localparam int NUM_CNT = NUM_CLASSES + 1;

  perf_state_e      state_q, state_d;
  logic             w_cnt_en;
  logic             w_exec_hit;
  logic             w_hit_target;
  logic [NUM_CNT-1:0] w_inc;
  logic [NUM_CNT-1:0] w_ovf;
  logic [CNT_W-1:0] w_live [NUM_CNT];
  logic [CNT_W-1:0] snap_q [NUM_CNT];

  assign w_cnt_en   = (state_q == ST_RUN) && gwe;
  assign w_exec_hit = (i_stall_class == CLS_W'(CLS_EXEC));
  // The edge that brings the exec count up to a non-zero target ends the run
  assign w_hit_target = w_cnt_en && w_exec_hit && (i_target != '0) &&
                        ((w_live[c_idx_exec] + CNT_W'(1)) == i_target);

  // Next-state logic: clear > stop > start; DONE is left only by clear
  always_comb begin
    state_d = state_q;
    if (i_clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (i_start && !i_stop) state_d = ST_RUN;
        ST_RUN: begin
          if (i_stop)            state_d = ST_IDLE;
          else if (w_hit_target) state_d = ST_DONE;
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Increment enables: slot 0 every counted cycle, slot k+1 for class k;
  // out-of-range classes only reach the total-cycle slot
  always_comb begin
    w_inc = '0;
    w_inc[c_idx_total] = w_cnt_en;
    for (int k = 0; k < NUM_CLASSES; k++) begin
      if (w_cnt_en && (int'(i_stall_class) == k)) w_inc[k+1] = 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    lc4_perf_counter #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE)
    ) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (i_clear),
      .inc_i (w_inc[g]),
      .cnt_o (w_live[g]),
      .ovf_o (w_ovf[g])
    );
  end

  // Snapshot bank captures pre-edge live values; clear leaves it untouched
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_CNT; k++) snap_q[k] <= '0;
    end else if (i_snap) begin
      for (int k = 0; k < NUM_CNT; k++) snap_q[k] <= w_live[k];
    end
  end

  // Zero-latency readout mux; unused select codes read as zero
  always_comb begin
    o_rd_data = '0;
    for (int k = 0; k < NUM_CNT; k++) begin
      if (int'(i_rd_sel) == k) o_rd_data = snap_q[k];
    end
  end

  assign o_ovf   = w_ovf;
  assign o_state = state_q;
  assign o_done  = (state_q == ST_DONE);

endmodule
`default_nettype wire
